// File: rtl/systolic_requant_packer.sv
// Requantizes rows of int32 systolic accumulators to int8 and packs them into
// 64-bit words, with a credit-checked pipeline feeding a ready/valid output FIFO.
module systolic_requant_packer #(
  parameter int unsigned LANES      = 8,
  parameter int unsigned ACC_W      = 32,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [31:0]            cfg_rows,
  input  logic [15:0]            cfg_scale,
  input  logic [4:0]             cfg_shift,
  input  logic [7:0]             cfg_zero,
  input  logic                   acc_valid,
  output logic                   acc_ready,
  input  logic [LANES*ACC_W-1:0] acc_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [63:0]            m_data,
  output logic                   m_last,
  output logic                   layer_done,
  output logic                   busy
);

  localparam int unsigned OUT_W = LANES * 8;
  localparam int unsigned P_W   = ACC_W + 17;
  localparam int unsigned R_W   = P_W + 1;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  if (OUT_W != 64) begin : g_bad_lanes
    $error("LANES*8 must equal 64");
  end
  if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of 2 and at least 4");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t                r_state;
  logic [31:0]           r_rows;
  logic [15:0]           r_scale;
  logic [4:0]            r_shift;
  logic signed [7:0]     r_zero;
  logic [31:0]           r_acc_cnt;
  logic [CNT_W-1:0]      r_used;
  logic                  r_layer_done;

  logic                  r_s1_valid;
  logic                  r_s1_last;
  logic signed [P_W-1:0] r_s1_p [LANES];
  logic                  r_s2_valid;
  logic                  r_s2_last;
  logic [OUT_W-1:0]      r_s2_data;

  logic [OUT_W:0]        r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_mem_cnt;
  logic                  r_m_valid;
  logic [OUT_W-1:0]      r_m_data;
  logic                  r_m_last;

  logic                  w_acc_fire;
  logic                  w_row_last;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_out_free;
  logic                  w_mem_empty;
  logic                  w_bypass;
  logic                  w_mem_wr;
  logic                  w_mem_rd;
  logic [CNT_W-1:0]      w_fifo_count;
  logic signed [P_W-1:0] w_prod [LANES];
  logic signed [R_W-1:0] w_bias;
  logic signed [R_W-1:0] w_sum  [LANES];
  logic signed [R_W-1:0] w_q    [LANES];
  logic [OUT_W-1:0]      w_pack;

  // Credit covers both pipeline stages plus FIFO storage, so an accepted row always has a slot.
  assign acc_ready  = (r_state == S_RUN) && (r_used < CNT_W'(FIFO_DEPTH));
  assign busy       = (r_state != S_IDLE);
  assign w_acc_fire = acc_valid && acc_ready;
  assign w_row_last = (r_acc_cnt == r_rows - 32'd1);

  assign w_push       = r_s2_valid;
  assign w_pop        = r_m_valid && m_ready;
  assign w_out_free   = !r_m_valid || m_ready;
  assign w_mem_empty  = (r_mem_cnt == '0);
  assign w_bypass     = w_out_free && w_mem_empty && w_push;
  assign w_mem_wr     = w_push && !w_bypass;
  assign w_mem_rd     = w_out_free && !w_mem_empty;
  assign w_fifo_count = r_mem_cnt + CNT_W'(r_m_valid);

  assign m_valid    = r_m_valid;
  assign m_data     = r_m_data;
  assign m_last     = r_m_last;
  assign layer_done = r_layer_done;

  assign w_bias = (r_shift == 5'd0) ? '0 : (R_W'(1) << (r_shift - 5'd1));

  // Stage 1 multiply and stage 2 round/shift/offset/saturate, per lane.
  always_comb begin
    w_pack = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      w_prod[i] = P_W'($signed(acc_data[ACC_W*i +: ACC_W])) * P_W'($signed({1'b0, r_scale}));
      w_sum[i]  = (R_W'(r_s1_p[i]) + w_bias) >>> r_shift;
      w_q[i]    = w_sum[i] + R_W'(r_zero);
      if (w_q[i] > R_W'(127)) begin
        w_pack[8*i +: 8] = 8'h7F;
      end else if (w_q[i] < R_W'(-128)) begin
        w_pack[8*i +: 8] = 8'h80;
      end else begin
        w_pack[8*i +: 8] = w_q[i][7:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(LANES); i++) begin
      if (w_acc_fire) r_s1_p[i] <= w_prod[i];
    end
    if (r_s1_valid) r_s2_data <= w_pack;
    if (w_mem_wr) r_mem[r_wr_ptr] <= {r_s2_last, r_s2_data};
  end

  // Control FSM, pipeline valids, credit counter and FIFO bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_rows       <= '0;
      r_scale      <= '0;
      r_shift      <= '0;
      r_zero       <= '0;
      r_acc_cnt    <= '0;
      r_used       <= '0;
      r_layer_done <= 1'b0;
      r_s1_valid   <= 1'b0;
      r_s1_last    <= 1'b0;
      r_s2_valid   <= 1'b0;
      r_s2_last    <= 1'b0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_mem_cnt    <= '0;
      r_m_valid    <= 1'b0;
      r_m_data     <= '0;
      r_m_last     <= 1'b0;
    end else begin
      r_layer_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (cfg_rows != 32'd0) begin
              r_rows    <= cfg_rows;
              r_scale   <= cfg_scale;
              r_shift   <= cfg_shift;
              r_zero    <= cfg_zero;
              r_acc_cnt <= '0;
              r_state   <= S_RUN;
            end else begin
              r_layer_done <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (w_acc_fire) begin
            r_acc_cnt <= r_acc_cnt + 32'd1;
            if (w_row_last) r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_pop && r_m_last) begin
            r_layer_done <= 1'b1;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      r_s1_valid <= w_acc_fire;
      if (w_acc_fire) r_s1_last <= w_row_last;
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) r_s2_last <= r_s1_last;
      r_used <= r_used + CNT_W'(w_acc_fire) - CNT_W'(w_pop);

      if (w_mem_wr) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_mem_rd) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_mem_cnt <= r_mem_cnt + CNT_W'(w_mem_wr) - CNT_W'(w_mem_rd);

      // Output register: memory head first, else bypass a fresh push when storage is empty.
      if (w_mem_rd) begin
        r_m_valid <= 1'b1;
        r_m_last  <= r_mem[r_rd_ptr][OUT_W];
        r_m_data  <= r_mem[r_rd_ptr][OUT_W-1:0];
      end else if (w_bypass) begin
        r_m_valid <= 1'b1;
        r_m_last  <= r_s2_last;
        r_m_data  <= r_s2_data;
      end else if (w_out_free) begin
        r_m_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (w_fifo_count <= CNT_W'(FIFO_DEPTH));
  end

endmodule

// File: tb/tb_systolic_requant_packer.sv
// Directed bench for systolic_requant_packer: identity, rounding, saturation,
// backpressure, random handshakes against a reference model, zero-row start and reset.
module tb_systolic_requant_packer;

  localparam int LANES = 8;
  localparam int ACC_W = 32;
  localparam int DEPTH = 16;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   start = 1'b0;
  logic [31:0]            cfg_rows = '0;
  logic [15:0]            cfg_scale = '0;
  logic [4:0]             cfg_shift = '0;
  logic [7:0]             cfg_zero = '0;
  logic                   acc_valid = 1'b0;
  logic                   acc_ready;
  logic [LANES*ACC_W-1:0] acc_data = '0;
  logic                   m_valid;
  logic                   m_ready = 1'b0;
  logic [63:0]            m_data;
  logic                   m_last;
  logic                   layer_done;
  logic                   busy;

  int n_vec = 0;
  int n_err = 0;
  logic [LANES*ACC_W-1:0] acc_rows [$];
  logic [63:0]            exp_q [$];

  systolic_requant_packer #(.LANES(LANES), .ACC_W(ACC_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_rows(cfg_rows), .cfg_scale(cfg_scale),
    .cfg_shift(cfg_shift), .cfg_zero(cfg_zero), .acc_valid(acc_valid), .acc_ready(acc_ready),
    .acc_data(acc_data), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last), .layer_done(layer_done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [LANES*ACC_W-1:0] pack_row(input int v [8]);
    logic [LANES*ACC_W-1:0] r;
    r = '0;
    for (int l = 0; l < LANES; l++) r[ACC_W*l +: ACC_W] = v[l];
    return r;
  endfunction

  function automatic logic [7:0] rq(input int acc, input int sc, input int sh, input int z);
    longint p;
    longint q;
    p = longint'(acc) * longint'(sc);
    if (sh > 0) p = p + (longint'(1) << (sh - 1));
    p = p >>> sh;
    q = p + longint'(z);
    if (q > 127) return 8'h7F;
    if (q < -128) return 8'h80;
    return q[7:0];
  endfunction

  function automatic logic [63:0] model_word(input int v [8], input int sc, input int sh, input int z);
    logic [63:0] w;
    for (int l = 0; l < LANES; l++) w[8*l +: 8] = rq(v[l], sc, sh, z);
    return w;
  endfunction

  // Runs one layer from acc_rows/exp_q; entered and left at posedge+1.
  task automatic run_layer(input int rows, input logic [15:0] sc, input logic [4:0] sh,
                           input logic [7:0] z, input int vpct, input int rpct,
                           input int stall, input bit chk_lat);
    int sent = 0;
    int got = 0;
    int cyc = 0;
    int dones = 0;
    int first_acc = -1;
    int first_val = -1;
    int limit;
    bit want_done = 1'b0;
    bit stalled = 1'b0;
    bit in_fire;
    logic [63:0] held_d = '0;
    logic held_l = 1'b0;
    limit = 20 * rows + 200;
    cfg_rows = 32'(rows); cfg_scale = sc; cfg_shift = sh; cfg_zero = z;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (dones == 0 && cyc < limit) begin
      acc_valid = (sent < rows) && ($urandom_range(99) < 32'(vpct));
      acc_data  = (sent < rows) ? acc_rows[sent] : '0;
      m_ready   = (cyc >= stall) && ($urandom_range(99) < 32'(rpct));
      @(negedge clk);
      if (cyc == 0) chk("busy_run", 64'(busy), 64'd1);
      if (want_done) begin
        chk("layer_done_pulse", 64'(layer_done), 64'd1);
        chk("busy_after_done", 64'(busy), 64'd0);
        want_done = 1'b0;
      end
      if (layer_done) dones++;
      if (stalled) begin
        chk("hold_valid", 64'(m_valid), 64'd1);
        chk("hold_data", m_data, held_d);
        chk("hold_last", 64'(m_last), 64'(held_l));
      end
      in_fire = acc_valid && acc_ready;
      if (in_fire && first_acc < 0) first_acc = cyc;
      if (m_valid && first_val < 0) first_val = cyc;
      if (m_valid && m_ready) begin
        if (got < rows) begin
          chk($sformatf("word%0d", got), m_data, exp_q[got]);
          chk($sformatf("last%0d", got), 64'(m_last), 64'(got == rows - 1));
        end else begin
          chk("extra_word", 64'(got), 64'(rows - 1));
        end
        if (m_last) want_done = 1'b1;
        got++;
      end
      stalled = m_valid && !m_ready;
      held_d  = m_data;
      held_l  = m_last;
      if (in_fire) sent++;
      if (stall > 0 && cyc == stall - 1) begin
        chk("accepts_at_full", 64'(sent), 64'(DEPTH));
        chk("ready_low_at_full", 64'(acc_ready), 64'd0);
      end
      @(posedge clk); #1;
      cyc++;
    end
    acc_valid = 1'b0;
    chk("word_count", 64'(got), 64'(rows));
    chk("done_count", 64'(dones), 64'd1);
    if (chk_lat) chk("latency", 64'(first_val - first_acc), 64'd3);
    acc_rows.delete();
    exp_q.delete();
  endtask

  initial begin
    int v [8];
    int sent;
    int sc;
    int sh;
    int z;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_acc_ready", 64'(acc_ready), 64'd0);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_data", m_data, 64'd0);
    chk("rst_m_last", 64'(m_last), 64'd0);
    chk("rst_layer_done", 64'(layer_done), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Identity: lanes 0,1,-1,127,-128,5,-5,100
    v = '{0, 1, -1, 127, -128, 5, -5, 100};
    for (int r = 0; r < 4; r++) begin
      acc_rows.push_back(pack_row(v));
      exp_q.push_back(64'h64FB_0580_7FFF_0100);
    end
    run_layer(4, 16'd1, 5'd0, 8'h00, 100, 100, 0, 1'b1);

    // Rounding half-up with shift 2, scale 3
    v = '{5, 6, -5, -6, 0, 0, 0, 0};
    acc_rows.push_back(pack_row(v));
    exp_q.push_back(64'h0000_0000_FCFC_0504);
    run_layer(1, 16'd3, 5'd2, 8'h00, 100, 100, 0, 1'b0);

    // Saturation with zero point -3
    v = '{1000000, -1000000, 0, 0, 0, 0, 0, 0};
    for (int r = 0; r < 2; r++) begin
      acc_rows.push_back(pack_row(v));
      exp_q.push_back(64'hFDFD_FDFD_FDFD_807F);
    end
    run_layer(2, 16'd1000, 5'd0, 8'hFD, 100, 100, 0, 1'b0);

    // Backpressure: 40 rows, downstream stalled for 50 cycles
    for (int r = 0; r < 40; r++) begin
      for (int l = 0; l < LANES; l++) v[l] = r * 3 - l * 7;
      acc_rows.push_back(pack_row(v));
      exp_q.push_back(model_word(v, 1, 0, 0));
    end
    run_layer(40, 16'd1, 5'd0, 8'h00, 100, 100, 50, 1'b0);

    // Random handshakes on both sides, 1000 rows
    sc = int'($urandom_range(1, 500));
    sh = int'($urandom_range(8, 14));
    z  = int'($urandom_range(0, 255)) - 128;
    for (int r = 0; r < 1000; r++) begin
      for (int l = 0; l < LANES; l++) v[l] = $signed($urandom) >>> $urandom_range(30, 12);
      acc_rows.push_back(pack_row(v));
      exp_q.push_back(model_word(v, sc, sh, z));
    end
    run_layer(1000, 16'(sc), 5'(sh), 8'(z), 50, 50, 0, 1'b0);

    // Zero-row start: no acceptance, done pulse next cycle
    cfg_rows = 32'd0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("zero_rows_done", 64'(layer_done), 64'd1);
    chk("zero_rows_ready", 64'(acc_ready), 64'd0);
    chk("zero_rows_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("zero_rows_done_clear", 64'(layer_done), 64'd0);
    @(posedge clk); #1;

    // Reset in the middle of a 10-row layer after 5 accepts
    v = '{0, 1, -1, 127, -128, 5, -5, 100};
    cfg_rows = 32'd10; cfg_scale = 16'd1; cfg_shift = 5'd0; cfg_zero = 8'h00;
    m_ready = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    sent = 0;
    for (int c = 0; c < 50 && sent < 5; c++) begin
      acc_valid = 1'b1;
      acc_data  = pack_row(v);
      @(negedge clk);
      if (acc_valid && acc_ready) sent++;
      @(posedge clk); #1;
    end
    chk("mid_accepts", 64'(sent), 64'd5);
    chk("mid_valid_before_rst", 64'(m_valid), 64'd1);
    acc_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_acc_ready", 64'(acc_ready), 64'd0);
    chk("mid_rst_m_valid", 64'(m_valid), 64'd0);
    chk("mid_rst_m_data", m_data, 64'd0);
    chk("mid_rst_m_last", 64'(m_last), 64'd0);
    chk("mid_rst_layer_done", 64'(layer_done), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Full layer after the reset
    for (int r = 0; r < 3; r++) begin
      acc_rows.push_back(pack_row(v));
      exp_q.push_back(64'h64FB_0580_7FFF_0100);
    end
    run_layer(3, 16'd1, 5'd0, 8'h00, 100, 100, 0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
